branch_predictor_unit: RTL and testbench

Parametrised fetch-side branch predictor for the 5-stage RV32 pipeline, replacing the fixed 256-entry PHT/BTB logic inside the fetch stage. It has three parts: a gshare direction predictor, a direct-mapped BTB that records branch kind, and a return-address stack (RAS). Fetch queries it combinationally every cycle. The EX stage trains it with one resolved control-flow instruction per cycle. It also keeps branch and mispredict performance counters.

---
 rtl/branch_predictor_unit.sv | 253 +++++++++++++++++++++++++
 tb/tb_branch_predictor_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit
// Fetch-side branch predictor: gshare direction predictor, direct-mapped
// BTB that remembers the kind of each control-flow instruction, and a
// circular return-address stack. Lookups are purely combinational from
// F_PC; training arrives from EX, at most one resolved instruction per cycle,
// and becomes visible to lookups from the following cycle.

module branch_predictor_unit #(
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  // fetch-side lookup
  input  logic [31:0]                    F_PC,
  output logic                           F_pred_taken,
  output logic [31:0]                    F_pred_target,
  output logic [$clog2(PHT_ENTRIES)-1:0] F_pht_idx,
  output logic                           F_btb_hit,
  // EX-side training
  input  logic                           ex_update_en,
  input  logic [31:0]                    ex_pc,
  input  logic [$clog2(PHT_ENTRIES)-1:0] ex_pht_idx,
  input  logic [1:0]                     ex_kind,
  input  logic                           ex_actual_taken,
  input  logic [31:0]                    ex_actual_target,
  input  logic                           ex_mispredict,
  // performance counters
  output logic [31:0]                    perf_branches,
  output logic [31:0]                    perf_mispredicts
);

  localparam int PIDX_W    = $clog2(PHT_ENTRIES);
  localparam int BIDX_W    = $clog2(BTB_ENTRIES);
  localparam int TAG_W     = 32 - BIDX_W - 2;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'b00,
    KIND_JUMP   = 2'b01,
    KIND_CALL   = 2'b10,
    KIND_RETURN = 2'b11
  } kind_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]           pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;

  logic                 btbValid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0]     btbTag_q    [BTB_ENTRIES];
  logic [31:0]          btbTarget_q [BTB_ENTRIES];
  kind_e                btbKind_q   [BTB_ENTRIES];

  logic [31:0]          rasStack_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] rasTop_q, rasTop_d;
  logic [RAS_CNT_W-1:0] rasCnt_q, rasCnt_d;

  logic [31:0]          perfBranches_q, perfBranches_d;
  logic [31:0]          perfMispredicts_q, perfMispredicts_d;

  // ---------------------------------------------------------------------------
  // Lookup-side signals
  // ---------------------------------------------------------------------------
  logic [PIDX_W-1:0]    ghrExt;
  logic [PIDX_W-1:0]    lookupPhtIdx;
  logic [BIDX_W-1:0]    lookupBtbIdx;
  logic [TAG_W-1:0]     lookupTag;
  logic                 lookupHit;
  kind_e                lookupKind;
  logic [31:0]          lookupBtbTarget;
  logic [31:0]          fallThrough;

  // ---------------------------------------------------------------------------
  // Update-side signals
  // ---------------------------------------------------------------------------
  kind_e                updKind;
  logic [BIDX_W-1:0]    updBtbIdx;
  logic [TAG_W-1:0]     updTag;
  logic                 phtWrite;
  logic [1:0]           phtNext;
  logic                 btbWrite;
  logic                 rasPush;
  logic                 rasPop;
  logic [RAS_PTR_W-1:0] rasTopInc;
  logic [RAS_PTR_W-1:0] rasTopDec;

  // Zero-extend the history to the PHT index width so GHR_BITS may be shorter
  always_comb begin
    ghrExt = '0;
    ghrExt[GHR_BITS-1:0] = ghr_q;
  end

  // Combinational prediction from the fetch PC and current table state
  always_comb begin
    lookupPhtIdx    = F_PC[PIDX_W+1:2] ^ ghrExt;
    lookupBtbIdx    = F_PC[BIDX_W+1:2];
    lookupTag       = F_PC[31:BIDX_W+2];
    lookupHit       = btbValid_q[lookupBtbIdx] && (btbTag_q[lookupBtbIdx] == lookupTag);
    lookupKind      = btbKind_q[lookupBtbIdx];
    lookupBtbTarget = btbTarget_q[lookupBtbIdx];
    fallThrough     = F_PC + 32'd4;

    F_pred_taken  = 1'b0;
    F_pred_target = fallThrough;
    if (lookupHit) begin
      case (lookupKind)
        KIND_BRANCH: begin
          F_pred_taken = pht_q[lookupPhtIdx][1];
          if (pht_q[lookupPhtIdx][1]) begin
            F_pred_target = lookupBtbTarget;
          end
        end
        KIND_JUMP, KIND_CALL: begin
          F_pred_taken  = 1'b1;
          F_pred_target = lookupBtbTarget;
        end
        KIND_RETURN: begin
          F_pred_taken  = 1'b1;
          F_pred_target = (rasCnt_q != '0) ? rasStack_q[rasTop_q] : lookupBtbTarget;
        end
        default: begin
          F_pred_taken  = 1'b0;
          F_pred_target = fallThrough;
        end
      endcase
    end

    F_pht_idx = lookupPhtIdx;
    F_btb_hit = lookupHit;
  end

  // Decode the EX training request into per-structure write enables
  always_comb begin
    updKind   = kind_e'(ex_kind);
    updBtbIdx = ex_pc[BIDX_W+1:2];
    updTag    = ex_pc[31:BIDX_W+2];

    phtWrite  = ex_update_en && (updKind == KIND_BRANCH);
    btbWrite  = ex_update_en && ex_actual_taken;
    rasPush   = ex_update_en && (updKind == KIND_CALL);
    rasPop    = ex_update_en && (updKind == KIND_RETURN) && (rasCnt_q != '0);

    // Saturating 2-bit counter step
    phtNext = pht_q[ex_pht_idx];
    if (ex_actual_taken) begin
      if (pht_q[ex_pht_idx] != 2'b11) begin
        phtNext = pht_q[ex_pht_idx] + 2'd1;
      end
    end else begin
      if (pht_q[ex_pht_idx] != 2'b00) begin
        phtNext = pht_q[ex_pht_idx] - 2'd1;
      end
    end
  end

  // Next-state for history, RAS pointer/count and performance counters
  always_comb begin
    rasTopInc = (rasTop_q == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : rasTop_q + 1'b1;
    rasTopDec = (rasTop_q == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : rasTop_q - 1'b1;

    ghr_d             = ghr_q;
    rasTop_d          = rasTop_q;
    rasCnt_d          = rasCnt_q;
    perfBranches_d    = perfBranches_q;
    perfMispredicts_d = perfMispredicts_q;

    if (phtWrite) begin
      ghr_d = (ghr_q << 1) | GHR_BITS'(ex_actual_taken);
    end

    // A full stack keeps its count; the push simply overwrites the oldest slot
    if (rasPush) begin
      rasTop_d = rasTopInc;
      if (rasCnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
        rasCnt_d = rasCnt_q + 1'b1;
      end
    end else if (rasPop) begin
      rasTop_d = rasTopDec;
      rasCnt_d = rasCnt_q - 1'b1;
    end

    if (ex_update_en) begin
      perfBranches_d = perfBranches_q + 32'd1;
      if (ex_mispredict) begin
        perfMispredicts_d = perfMispredicts_q + 32'd1;
      end
    end
  end

  // Scalar state registers; reset wins over any concurrent update
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q             <= '0;
      rasTop_q          <= RAS_PTR_W'(RAS_DEPTH - 1);
      rasCnt_q          <= '0;
      perfBranches_q    <= '0;
      perfMispredicts_q <= '0;
    end else begin
      ghr_q             <= ghr_d;
      rasTop_q          <= rasTop_d;
      rasCnt_q          <= rasCnt_d;
      perfBranches_q    <= perfBranches_d;
      perfMispredicts_q <= perfMispredicts_d;
    end
  end

  // Pattern history table: every counter starts weakly not-taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (phtWrite) begin
      pht_q[ex_pht_idx] <= phtNext;
    end
  end

  // BTB: only taken control flow is recorded; aliasing entries are replaced
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btbValid_q[i] <= 1'b0;
      end
    end else if (btbWrite) begin
      btbValid_q[updBtbIdx] <= 1'b1;
    end
  end

  // BTB payload needs no reset since the valid bit guards it
  always_ff @(posedge clk) begin
    if (!rst && btbWrite) begin
      btbTag_q[updBtbIdx]    <= updTag;
      btbTarget_q[updBtbIdx] <= ex_actual_target;
      btbKind_q[updBtbIdx]   <= updKind;
    end
  end

  // Return-address storage; a call writes its fall-through into the new top slot
  always_ff @(posedge clk) begin
    if (!rst && rasPush) begin
      rasStack_q[rasTopInc] <= ex_pc + 32'd4;
    end
  end

  assign perf_branches    = perfBranches_q;
  assign perf_mispredicts = perfMispredicts_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit
// Directed vectors with hand-computed expectations. Stimulus pushes the
// expected lookup response into a queue; an independent monitor pops and
// compares whenever a lookup is presented.

module tb_branch_predictor_unit;

  logic        clk;
  logic        rst;
  logic [31:0] F_PC;
  logic        F_pred_taken;
  logic [31:0] F_pred_target;
  logic [7:0]  F_pht_idx;
  logic        F_btb_hit;
  logic        ex_update_en;
  logic [31:0] ex_pc;
  logic [7:0]  ex_pht_idx;
  logic [1:0]  ex_kind;
  logic        ex_actual_taken;
  logic [31:0] ex_actual_target;
  logic        ex_mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  typedef struct {
    string       name;
    logic        expHit;
    logic        expTaken;
    logic [31:0] expTarget;
    bit          checkIdx;
    logic [7:0]  expIdx;
    logic [31:0] expBranches;
    logic [31:0] expMispredicts;
  } expect_t;

  expect_t     expQ[$];
  logic        lookupStrobe;
  int          checks;
  int          errors;
  logic [31:0] modelBranches;
  logic [31:0] modelMispredicts;

  branch_predictor_unit dut (
    .clk              (clk),
    .rst              (rst),
    .F_PC             (F_PC),
    .F_pred_taken     (F_pred_taken),
    .F_pred_target    (F_pred_target),
    .F_pht_idx        (F_pht_idx),
    .F_btb_hit        (F_btb_hit),
    .ex_update_en     (ex_update_en),
    .ex_pc            (ex_pc),
    .ex_pht_idx       (ex_pht_idx),
    .ex_kind          (ex_kind),
    .ex_actual_taken  (ex_actual_taken),
    .ex_actual_target (ex_actual_target),
    .ex_mispredict    (ex_mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented lookup and compares it
  always @(negedge clk) begin
    if (lookupStrobe) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard actual=lookup required=queued_expectation");
      end else begin
        expect_t e;
        e = expQ.pop_front();
        compareVal(e.name, "hit",    {31'd0, F_btb_hit},    {31'd0, e.expHit});
        compareVal(e.name, "taken",  {31'd0, F_pred_taken}, {31'd0, e.expTaken});
        compareVal(e.name, "target", F_pred_target,         e.expTarget);
        if (e.checkIdx) begin
          compareVal(e.name, "pht_idx", {24'd0, F_pht_idx}, {24'd0, e.expIdx});
        end
        compareVal(e.name, "perf_branches",    perf_branches,    e.expBranches);
        compareVal(e.name, "perf_mispredicts", perf_mispredicts, e.expMispredicts);
      end
    end
  end

  // One EX update cycle (optionally with rst asserted); entry and exit just after a rising edge
  task automatic applyStimulus(input bit doRst, input logic [1:0] kind,
                               input logic [31:0] pc, input logic [7:0] idx,
                               input logic taken, input logic [31:0] target,
                               input logic misp);
    rst              = doRst;
    ex_update_en     = 1'b1;
    ex_kind          = kind;
    ex_pc            = pc;
    ex_pht_idx       = idx;
    ex_actual_taken  = taken;
    ex_actual_target = target;
    ex_mispredict    = misp;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    ex_update_en = 1'b0;
    if (doRst) begin
      modelBranches    = 32'd0;
      modelMispredicts = 32'd0;
    end else begin
      modelBranches = modelBranches + 32'd1;
      if (misp) modelMispredicts = modelMispredicts + 32'd1;
    end
  endtask

  // Present a lookup and queue what the monitor should see for it
  task automatic checkOutput(input string name, input logic [31:0] pc,
                             input logic hit, input logic taken,
                             input logic [31:0] target,
                             input bit checkIdx, input logic [7:0] idx);
    expect_t e;
    e.name           = name;
    e.expHit         = hit;
    e.expTaken       = taken;
    e.expTarget      = target;
    e.checkIdx       = checkIdx;
    e.expIdx         = idx;
    e.expBranches    = modelBranches;
    e.expMispredicts = modelMispredicts;
    F_PC = pc;
    expQ.push_back(e);
    lookupStrobe = 1'b1;
    @(negedge clk);
    #1;
    lookupStrobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    modelBranches    = 32'd0;
    modelMispredicts = 32'd0;
    lookupStrobe     = 1'b0;
    rst              = 1'b1;
    F_PC             = 32'd0;
    ex_update_en     = 1'b0;
    ex_pc            = 32'd0;
    ex_pht_idx       = 8'd0;
    ex_kind          = 2'b00;
    ex_actual_taken  = 1'b0;
    ex_actual_target = 32'd0;
    ex_mispredict    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset lookup");
    checkOutput("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 8'h40);

    $display("[TB] gshare and saturation");
    applyStimulus(1'b0, 2'b00, 32'h78, 8'h10, 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h78, 8'h10, 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h78, 8'h10, 1'b1, 32'h200, 1'b0);
    applyStimulus(1'b0, 2'b00, 32'h78, 8'h10, 1'b0, 32'h200, 1'b1);
    // GHR = 0x0E, PHT[0x10] = 10
    checkOutput("gshare_taken", 32'h78, 1'b1, 1'b1, 32'h200, 1'b1, 8'h10);
    // PHT[0x10] -> 01, GHR = 0x1C; lookup now indexes PHT[0x02] = 01
    applyStimulus(1'b0, 2'b00, 32'h78, 8'h10, 1'b0, 32'h200, 1'b0);
    checkOutput("gshare_not_taken", 32'h78, 1'b1, 1'b0, 32'h7C, 1'b1, 8'h02);

    $display("[TB] BTB aliasing");
    applyStimulus(1'b0, 2'b01, 32'h100, 8'h00, 1'b1, 32'h500, 1'b1);
    applyStimulus(1'b0, 2'b01, 32'h200, 8'h00, 1'b1, 32'h600, 1'b1);
    checkOutput("alias_evicted", 32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 8'h5C);
    checkOutput("alias_winner",  32'h200, 1'b1, 1'b1, 32'h600, 1'b1, 8'h9C);

    $display("[TB] return address stack");
    applyStimulus(1'b0, 2'b10, 32'h40,  8'h00, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b0, 2'b11, 32'h310, 8'h00, 1'b1, 32'h44,  1'b0);
    applyStimulus(1'b0, 2'b10, 32'h50,  8'h00, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b0, 2'b10, 32'h60,  8'h00, 1'b1, 32'h300, 1'b0);
    checkOutput("call_hit",   32'h40,  1'b1, 1'b1, 32'h300, 1'b0, 8'h00);
    checkOutput("ras_return", 32'h310, 1'b1, 1'b1, 32'h64,  1'b0, 8'h00);
    // Record a second return site away from the overflow calls' BTB slots
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h64, 1'b0);

    $display("[TB] RAS overflow");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b10, 32'h1000 + 32'(i) * 32'h10, 8'h00, 1'b1, 32'h300, 1'b0);
    end
    checkOutput("ras_ovf_0", 32'h2F0, 1'b1, 1'b1, 32'h1044, 1'b0, 8'h00);
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h1044, 1'b0);
    checkOutput("ras_ovf_1", 32'h2F0, 1'b1, 1'b1, 32'h1034, 1'b0, 8'h00);
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h1034, 1'b0);
    checkOutput("ras_ovf_2", 32'h2F0, 1'b1, 1'b1, 32'h1024, 1'b0, 8'h00);
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h1024, 1'b0);
    checkOutput("ras_ovf_3", 32'h2F0, 1'b1, 1'b1, 32'h1014, 1'b0, 8'h00);
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h2000, 1'b1);
    checkOutput("ras_empty_fallback", 32'h2F0, 1'b1, 1'b1, 32'h2000, 1'b0, 8'h00);
    // Pop on an empty stack must not disturb the count
    applyStimulus(1'b0, 2'b11, 32'h2F0, 8'h00, 1'b1, 32'h2000, 1'b0);
    applyStimulus(1'b0, 2'b10, 32'h1050, 8'h00, 1'b1, 32'h300, 1'b0);
    checkOutput("ras_underflow_noop", 32'h2F0, 1'b1, 1'b1, 32'h1054, 1'b0, 8'h00);

    $display("[TB] performance counters");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    modelBranches    = 32'd0;
    modelMispredicts = 32'd0;
    checkOutput("post_reset_lookup", 32'h200, 1'b0, 1'b0, 32'h204, 1'b1, 8'h80);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b00, 32'h400 + 32'(i) * 32'd4, 8'(i), 1'b0, 32'h0,
                    (i == 1 || i == 4 || i == 7) ? 1'b1 : 1'b0);
    end
    checkOutput("perf_10_3", 32'h900, 1'b0, 1'b0, 32'h904, 1'b0, 8'h00);

    $display("[TB] reset beats update");
    applyStimulus(1'b1, 2'b01, 32'h800, 8'h00, 1'b1, 32'h900, 1'b1);
    checkOutput("reset_discards_update", 32'h800, 1'b0, 1'b0, 32'h804, 1'b1, 8'h00);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
